num_disp_scan: RTL and testbench

Display back-end for the 4-bit up/down counter value. It registers the counter's `num` output and shows it as decimal on a two-digit, time-multiplexed, common-anode 7-segment display, either unsigned (0..15) or signed two's complement (-8..7). It also raises a timed wrap indicator when the counter rolls over. It sits directly downstream of the counter, on the same clock and reset.

---
 rtl/num_disp_scan.sv | 133 +++++++++++++
 tb/tb_num_disp_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/num_disp_scan.sv
// Two-digit time-multiplexed decimal display for a 4-bit counter value, with an
// unsigned/signed view and a retriggerable, timed wrap-around indicator.
module num_disp_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int WRAP_HOLD = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] num,
    input  logic       mode,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap_led
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int WRAP_W = $clog2(WRAP_HOLD + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [WRAP_W-1:0] WRAP_LOAD = WRAP_W'(WRAP_HOLD);

    // Digit codes: 0..9 are numerals, the rest are glyphs.
    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_MINUS = 4'd11;

    logic [3:0]        num_q_reg, num_p_reg;
    logic [SCAN_W-1:0] scan_cnt_reg, scan_cnt_next;
    logic              dig_reg, dig_next;
    logic [6:0]        seg_reg, seg_next;
    logic [1:0]        an_reg, an_next;
    logic [WRAP_W-1:0] wrap_cnt_reg, wrap_cnt_next;
    logic              wrap_led_reg;

    logic              scan_last;
    logic              wrap_evt;
    logic [3:0]        mag;
    logic [3:0]        ones_code, tens_code, digit_code;

    function automatic logic [6:0] seg_pattern(input logic [3:0] code);
        case (code)
            4'd0:       seg_pattern = 7'b1000000;
            4'd1:       seg_pattern = 7'b1111001;
            4'd2:       seg_pattern = 7'b0100100;
            4'd3:       seg_pattern = 7'b0110000;
            4'd4:       seg_pattern = 7'b0011001;
            4'd5:       seg_pattern = 7'b0010010;
            4'd6:       seg_pattern = 7'b0000010;
            4'd7:       seg_pattern = 7'b1111000;
            4'd8:       seg_pattern = 7'b0000000;
            4'd9:       seg_pattern = 7'b0010000;
            CODE_MINUS: seg_pattern = 7'b0111111;
            default:    seg_pattern = 7'b1111111;
        endcase
    endfunction

    // Prescaler and digit select
    always_comb begin
        scan_last     = (scan_cnt_reg == SCAN_LAST);
        scan_cnt_next = scan_last ? '0 : scan_cnt_reg + SCAN_W'(1);
        dig_next      = dig_reg ^ scan_last;
    end

    // Decimal decode; in signed view the magnitude of -8 still fits in 4 bits.
    always_comb begin
        mag       = num_q_reg;
        ones_code = num_q_reg;
        tens_code = CODE_BLANK;
        if (mode) begin
            if (num_q_reg[3]) begin
                mag       = ~num_q_reg + 4'd1;
                tens_code = CODE_MINUS;
            end
            ones_code = mag;
        end else if (num_q_reg >= 4'd10) begin
            ones_code = num_q_reg - 4'd10;
            tens_code = 4'd1;
        end
        digit_code = dig_reg ? tens_code : ones_code;
        seg_next   = seg_pattern(digit_code);
    end

    // Anode drive: an[0] low while ones are selected, an[1] low for tens.
    for (genvar gi = 0; gi < 2; gi++) begin : g_an
        if (gi == 0) begin : g_ones
            assign an_next[gi] = dig_reg;
        end else begin : g_tens
            assign an_next[gi] = ~dig_reg;
        end
    end

    // Wrap classification uses the live mode so a mode change acts immediately.
    always_comb begin
        if (mode)
            wrap_evt = ((num_p_reg == 4'd7) && (num_q_reg == 4'd8)) ||
                       ((num_p_reg == 4'd8) && (num_q_reg == 4'd7));
        else
            wrap_evt = ((num_p_reg == 4'd15) && (num_q_reg == 4'd0)) ||
                       ((num_p_reg == 4'd0)  && (num_q_reg == 4'd15));

        if (wrap_evt)
            wrap_cnt_next = WRAP_LOAD;
        else if (wrap_cnt_reg != '0)
            wrap_cnt_next = wrap_cnt_reg - WRAP_W'(1);
        else
            wrap_cnt_next = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_q_reg    <= '0;
            num_p_reg    <= '0;
            scan_cnt_reg <= '0;
            dig_reg      <= 1'b0;
            seg_reg      <= 7'b1111111;
            an_reg       <= 2'b11;
            wrap_cnt_reg <= '0;
            wrap_led_reg <= 1'b0;
        end else begin
            num_q_reg    <= num;
            num_p_reg    <= num_q_reg;
            scan_cnt_reg <= scan_cnt_next;
            dig_reg      <= dig_next;
            seg_reg      <= seg_next;
            an_reg       <= an_next;
            wrap_cnt_reg <= wrap_cnt_next;
            wrap_led_reg <= (wrap_cnt_next != '0);
        end
    end

    assign seg      = seg_reg;
    assign an       = an_reg;
    assign wrap_led = wrap_led_reg;

endmodule

// File: tb/tb_num_disp_scan.sv
// Directed bench for num_disp_scan with SCAN_DIV=4, WRAP_HOLD=8: reset values,
// digit cadence, unsigned/signed decode, wrap hold/retrigger and async reset.
module tb_num_disp_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] num;
    logic       mode;
    logic [6:0] seg;
    logic [1:0] an;
    logic       wrap_led;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int run;

    num_disp_scan #(.SCAN_DIV(4), .WRAP_HOLD(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .num      (num),
        .mode     (mode),
        .seg      (seg),
        .an       (an),
        .wrap_led (wrap_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later; cyc counts edges since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Digit shown on the outputs after edge cyc: each slot lasts 4 edges, ones first.
    function automatic int shown_dig();
        return ((cyc - 1) / 4) % 2;
    endfunction

    task automatic goto_slot(input int d);
        while (shown_dig() != d) tick();
    endtask

    task automatic show(input string tag, input logic [6:0] ones, input logic [6:0] tens);
        tick();
        tick();
        goto_slot(0);
        check({tag, "_ones_an"}, 32'(an), 32'(2'b10));
        check({tag, "_ones_seg"}, 32'(seg), 32'(ones));
        goto_slot(1);
        check({tag, "_tens_an"}, 32'(an), 32'(2'b01));
        check({tag, "_tens_seg"}, 32'(seg), 32'(tens));
    endtask

    task automatic measure_hold(input int start);
        run = start;
        for (int i = 0; i < 30 && wrap_led; i++) begin
            tick();
            if (wrap_led) run++;
        end
    endtask

    initial begin
        rst  = 1'b0;
        num  = 4'd9;
        mode = 1'b0;

        // Reset held
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'd3);
        check("rst_led", 32'(wrap_led), 32'd0);

        @(negedge clk);
        rst = 1'b1;
        cyc = 0;

        // First edge displays the reset-time num_q (0), then 9 on the ones slot
        tick();
        check("first_an", 32'(an), 32'(2'b10));
        check("first_seg", 32'(seg), 32'(7'b1000000));
        tick();
        check("nine_ones_seg", 32'(seg), 32'(7'b0010000));
        for (int k = 3; k <= 12; k++) begin
            tick();
            check($sformatf("cad_an_c%0d", cyc), 32'(an),
                  (shown_dig() == 0) ? 32'(2'b10) : 32'(2'b01));
            check($sformatf("cad_seg_c%0d", cyc), 32'(seg),
                  (shown_dig() == 0) ? 32'(7'b0010000) : 32'(7'b1111111));
        end

        // Decode patterns
        num = 4'd13;
        show("u13", 7'b0110000, 7'b1111001);
        mode = 1'b1;
        num  = 4'b1011;
        show("s_m5", 7'b0010010, 7'b0111111);
        num = 4'b1000;
        show("s_m8", 7'b0000000, 7'b0111111);

        // Unsigned wrap 15 -> 0
        mode = 1'b0;
        num  = 4'd15;
        repeat (3) tick();
        check("pre_wrap_led", 32'(wrap_led), 32'd0);
        num = 4'd0;
        tick();
        check("wrap_n1", 32'(wrap_led), 32'd0);
        tick();
        check("wrap_n2", 32'(wrap_led), 32'd1);
        measure_hold(1);
        check("wrap_hold_len", 32'(run), 32'd8);

        // Retrigger: 15 -> 0, then 0 -> 15 at hold cycle 5
        num = 4'd15;
        repeat (12) tick();
        check("retrig_idle", 32'(wrap_led), 32'd0);
        num = 4'd0;
        tick();
        tick();
        check("retrig_rise", 32'(wrap_led), 32'd1);
        repeat (4) tick();
        check("retrig_hc5", 32'(wrap_led), 32'd1);
        num = 4'd15;
        measure_hold(5);
        check("retrig_len", 32'(run), 32'd14);

        // Signed: -1 -> 0 is not a wrap, 7 -> 8 is
        mode = 1'b1;
        num  = 4'd0;
        repeat (3) tick();
        check("s_m1to0_a", 32'(wrap_led), 32'd0);
        repeat (5) tick();
        check("s_m1to0_b", 32'(wrap_led), 32'd0);
        num = 4'd7;
        repeat (3) tick();
        check("s_0to7", 32'(wrap_led), 32'd0);
        num = 4'd8;
        tick();
        tick();
        check("s_7to8_rise", 32'(wrap_led), 32'd1);
        measure_hold(1);
        check("s_7to8_len", 32'(run), 32'd8);

        // Async reset with wrap_led high and the tens digit selected
        num = 4'd7;
        tick();
        tick();
        check("pre_rst_led", 32'(wrap_led), 32'd1);
        while (((cyc / 4) % 2) != 1) tick();
        check("pre_rst_led2", 32'(wrap_led), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_an", 32'(an), 32'd3);
        check("arst_led", 32'(wrap_led), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        tick();
        check("post_rst_an", 32'(an), 32'(2'b10));
        check("post_rst_seg", 32'(seg), 32'(7'b1000000));
        check("post_rst_led", 32'(wrap_led), 32'd0);
        tick();
        check("post_rst_seg7", 32'(seg), 32'(7'b1111000));
        tick();
        check("post_rst_led2", 32'(wrap_led), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
